// File: rtl/iob_sync_asym_fifo.sv
// Single-clock FIFO with asymmetric write/read widths, stored as narrow words.
// Define IOB_ASYM_FIFO_LEVEL_EN to expose the occupancy count on the level port.
module iob_sync_asym_fifo #(
  parameter int unsigned W_DATA_W = 32,
  parameter int unsigned R_DATA_W = 8,
  parameter int unsigned ADDR_W   = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty
`ifdef IOB_ASYM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]     level
`endif
);

  localparam int unsigned MIN_W = (W_DATA_W < R_DATA_W) ? W_DATA_W : R_DATA_W;
  localparam int unsigned W_R   = W_DATA_W / MIN_W;
  localparam int unsigned R_R   = R_DATA_W / MIN_W;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [MIN_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic [ADDR_W:0]   cnt;
  logic [ADDR_W:0]   free_cnt;
  logic              wr_acc;
  logic              rd_acc;

  always_comb begin
    free_cnt = (ADDR_W+1)'(DEPTH) - cnt;
    w_full   = free_cnt < (ADDR_W+1)'(W_R);
    r_empty  = cnt < (ADDR_W+1)'(R_R);
    wr_acc   = w_en & ~w_full;
    rd_acc   = r_en & ~r_empty;
  end

`ifdef IOB_ASYM_FIFO_LEVEL_EN
  assign level = cnt;
`endif

  // Accesses are ratio-aligned, so wptr+k never crosses the wrap point.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned k = 0; k < W_R; k++) begin
        mem[wptr + ADDR_W'(k)] <= w_data[k*MIN_W +: MIN_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= '0;
    end else if (rd_acc) begin
      for (int unsigned k = 0; k < R_R; k++) begin
        r_data[k*MIN_W +: MIN_W] <= mem[rptr + ADDR_W'(k)];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + ADDR_W'(W_R);
      if (rd_acc) rptr <= rptr + ADDR_W'(R_R);
      cnt <= cnt + (wr_acc ? (ADDR_W+1)'(W_R) : '0) - (rd_acc ? (ADDR_W+1)'(R_R) : '0);
    end
  end

endmodule

// File: tb/tb_iob_sync_asym_fifo.sv
// Bench for iob_sync_asym_fifo: one 8->32 and one 32->8 instance, each checked
// against a byte-queue reference model.
module tb_iob_sync_asym_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // narrow-write / wide-read instance
  logic        n_w_en, n_r_en, n_w_full, n_r_empty;
  logic [7:0]  n_w_data;
  logic [31:0] n_r_data;
  // wide-write / narrow-read instance
  logic        w_w_en, w_r_en, w_w_full, w_r_empty;
  logic [31:0] w_w_data;
  logic [7:0]  w_r_data;
`ifdef IOB_ASYM_FIFO_LEVEL_EN
  logic [4:0]  n_level, w_level;
`endif

  iob_sync_asym_fifo #(.W_DATA_W(8), .R_DATA_W(32), .ADDR_W(4)) u_n2w (
    .clk(clk), .rst(rst), .w_en(n_w_en), .w_data(n_w_data), .w_full(n_w_full),
    .r_en(n_r_en), .r_data(n_r_data), .r_empty(n_r_empty)
`ifdef IOB_ASYM_FIFO_LEVEL_EN
    , .level(n_level)
`endif
  );

  iob_sync_asym_fifo #(.W_DATA_W(32), .R_DATA_W(8), .ADDR_W(4)) u_w2n (
    .clk(clk), .rst(rst), .w_en(w_w_en), .w_data(w_w_data), .w_full(w_w_full),
    .r_en(w_r_en), .r_data(w_r_data), .r_empty(w_r_empty)
`ifdef IOB_ASYM_FIFO_LEVEL_EN
    , .level(w_level)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  qn[$];
  logic [7:0]  qw[$];
  logic [31:0] en_rdata;
  logic [7:0]  ew_rdata;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    check("n_rdata", 64'(n_r_data), 64'(en_rdata));
    check("n_full",  64'(n_w_full), 64'(qn.size() > 15));
    check("n_empty", 64'(n_r_empty), 64'(qn.size() < 4));
    check("w_rdata", 64'(w_r_data), 64'(ew_rdata));
    check("w_full",  64'(w_w_full), 64'(qw.size() > 12));
    check("w_empty", 64'(w_r_empty), 64'(qw.size() < 1));
`ifdef IOB_ASYM_FIFO_LEVEL_EN
    check("n_level", 64'(n_level), 64'(qn.size()));
    check("w_level", 64'(w_level), 64'(qw.size()));
`endif
  endtask

  // One clock: acceptance decided from the model's pre-edge occupancy.
  task automatic cycle();
    bit n_wa, n_ra, w_wa, w_ra;
    n_wa = n_w_en && (qn.size() < 16);
    n_ra = n_r_en && (qn.size() >= 4);
    w_wa = w_w_en && (qw.size() <= 12);
    w_ra = w_r_en && (qw.size() >= 1);
    @(posedge clk);
    if (n_ra) for (int b = 0; b < 4; b++) en_rdata[8*b +: 8] = qn.pop_front();
    if (n_wa) qn.push_back(n_w_data);
    if (w_ra) ew_rdata = qw.pop_front();
    if (w_wa) for (int b = 0; b < 4; b++) qw.push_back(w_w_data[8*b +: 8]);
    #1;
    check_state();
  endtask

  task automatic idle();
    n_w_en = 0; n_r_en = 0; w_w_en = 0; w_r_en = 0;
  endtask

  task automatic nw(input logic [7:0] d);
    idle(); n_w_en = 1; n_w_data = d; cycle(); idle();
  endtask

  task automatic nr();
    idle(); n_r_en = 1; cycle(); idle();
  endtask

  task automatic ww(input logic [31:0] d);
    idle(); w_w_en = 1; w_w_data = d; cycle(); idle();
  endtask

  task automatic wr();
    idle(); w_r_en = 1; cycle(); idle();
  endtask

  task automatic do_reset();
    rst = 1;
    #1;
    qn.delete(); qw.delete(); en_rdata = '0; ew_rdata = '0;
    check_state();
    #3 rst = 0;
  endtask

  initial begin
    logic [31:0] e;
    int rd_idx;
    int wprob;
    idle();
    n_w_data = '0; w_w_data = '0;
    en_rdata = '0; ew_rdata = '0;
    rst = 1;
    #12;
    check_state();
    rst = 0;

    // narrow-to-wide packing
    nw(8'h11); nw(8'h22); nw(8'h33);
    check("pack_empty3", 64'(n_r_empty), 64'd1);
    nw(8'h44);
    check("pack_empty4", 64'(n_r_empty), 64'd0);
    nr();
    check("pack_word", 64'(n_r_data), 64'h44332211);
    check("pack_drained", 64'(n_r_empty), 64'd1);

    // wide-to-narrow unpacking
    ww(32'hAABBCCDD);
    wr(); check("unpack0", 64'(w_r_data), 64'hDD);
    wr(); check("unpack1", 64'(w_r_data), 64'hCC);
    wr(); check("unpack2", 64'(w_r_data), 64'hBB);
    wr(); check("unpack3", 64'(w_r_data), 64'hAA);
    check("unpack_empty", 64'(w_r_empty), 64'd1);

    // full and overflow
    for (int i = 0; i < 4; i++) ww(32'h10203040 + 32'(i));
    check("ovf_full", 64'(w_w_full), 64'd1);
    ww(32'hDEADBEEF);
    check("ovf_size", 64'(qw.size()), 64'd16);
    for (int i = 0; i < 16; i++) wr();
    check("ovf_last", 64'(w_r_data), 64'h10);
    check("ovf_empty", 64'(w_r_empty), 64'd1);

    // wrap-around with interleaved reads
    rd_idx = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      n_w_en = 1; n_w_data = 8'(i);
      n_r_en = !n_r_empty;
      cycle();
      if (n_r_en) begin
        for (int b = 0; b < 4; b++) e[8*b +: 8] = 8'(4*rd_idx + b);
        check("wrap_word", 64'(n_r_data), 64'(e));
        rd_idx++;
      end
    end
    idle();
    for (int t = 0; t < 20 && rd_idx < 10; t++) begin
      n_r_en = !n_r_empty;
      cycle();
      if (n_r_en) begin
        for (int b = 0; b < 4; b++) e[8*b +: 8] = 8'(4*rd_idx + b);
        check("wrap_word", 64'(n_r_data), 64'(e));
        rd_idx++;
      end
    end
    idle();
    check("wrap_count", 64'(rd_idx), 64'd10);

    // simultaneous read and write at level 4
    nw(8'hA1); nw(8'hA2); nw(8'hA3); nw(8'hA4);
    idle(); n_w_en = 1; n_w_data = 8'hA5; n_r_en = 1; cycle(); idle();
    check("simul_word", 64'(n_r_data), 64'hA4A3A2A1);
    check("simul_size", 64'(qn.size()), 64'd1);

    // read while empty leaves r_data alone
    nr();
    check("rd_empty_hold", 64'(n_r_data), 64'hA4A3A2A1);
    wr();
    check("w_rd_empty_hold", 64'(w_r_data), 64'h10);

    // asynchronous reset with content present
    for (int i = 0; i < 7; i++) nw(8'(8'hB0 + i));
    ww(32'h01234567); ww(32'h89ABCDEF);
    do_reset();
    check("rst_n_data", 64'(n_r_data), 64'd0);
    check("rst_n_empty", 64'(n_r_empty), 64'd1);
    nw(8'h5A); nw(8'h5B); nw(8'h5C); nw(8'h5D); nr();
    check("post_rst_word", 64'(n_r_data), 64'h5D5C5B5A);

    // randomized traffic with phases biased toward fill and drain
    for (int i = 0; i < 1200; i++) begin
      wprob = ((i / 100) % 2 == 0) ? 80 : 25;
      if (i == 600) begin
        @(negedge clk);
        do_reset();
      end
      n_w_en   = ($urandom_range(99) < 32'(wprob));
      n_w_data = 8'($urandom);
      n_r_en   = ($urandom_range(99) < 32'(100 - wprob));
      w_w_en   = ($urandom_range(99) < 32'(wprob));
      w_w_data = $urandom;
      w_r_en   = ($urandom_range(99) < 32'(100 - wprob));
      cycle();
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
